// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line synchroniser.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_state_e;

  localparam logic [1:0] PS2_ERR_NONE  = 2'b00;
  localparam logic [1:0] PS2_ERR_START = 2'b01;
  localparam logic [1:0] PS2_ERR_NACK  = 2'b10;
  localparam logic [1:0] PS2_ERR_FRAME = 2'b11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake and status bundle between a command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_line_sync.sv
// 2-flop synchroniser for one PS/2 pin with falling-edge pulse.
// Optional stability filter enabled by PS2_HOST_TX_GLITCH_FILTER_EN.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic filt_level;

`ifdef PS2_HOST_TX_GLITCH_FILTER_EN
  logic       flt_q, flt_d;
  logic [1:0] stab_q, stab_d;

  // A new level is taken only on the 4th consecutive differing sample.
  always_comb begin
    flt_d  = flt_q;
    stab_d = '0;
    if (sync2_q != flt_q) begin
      if (stab_q == 2'd3) begin
        flt_d = sync2_q;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q  <= 1'b1;
      stab_q <= '0;
    end else begin
      flt_q  <= flt_d;
      stab_q <= stab_d;
    end
  end

  assign filt_level = flt_q;
`else
  assign filt_level = sync2_q;
`endif

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    prev_d  = filt_level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = filt_level;
  assign fall  = prev_q & ~filt_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift, ACK check.
// Clock-line glitch filtering is enabled by defining PS2_HOST_TX_GLITCH_FILTER_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ           = 25000000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000
) (
  input  logic         clk25,
  input  logic         rst,
  ps2_host_tx_if.slave tx_if,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int CYC_PER_US  = CLK_HZ / 1000000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int START_CYC   = CYC_PER_US * START_TIMEOUT_US;
  localparam int FRAME_CYC   = CYC_PER_US * FRAME_TIMEOUT_US;
  localparam int MAX_CYC     = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam int CW          = $clog2(MAX_CYC + 1);

  logic clk_level, clk_fall, dat_level, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk    (clk25),
    .rst    (rst),
    .pin_in (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk    (clk25),
    .rst    (rst),
    .pin_in (ps2_dat_in),
    .level  (dat_level),
    .fall   (dat_fall_unused)
  );

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic [1:0]    err_code_q, err_code_d;

  // cnt_q is shared: inhibit length, RTS wait, then the frame timer from edge 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    edge_cnt_d = edge_cnt_q;
    data_d     = data_q;
    par_d      = par_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_if.tx_valid) begin
          data_d     = tx_if.tx_data;
          par_d      = odd_parity(tx_if.tx_data);
          clk_oe_d   = 1'b1;
          err_code_d = PS2_ERR_NONE;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RTS;
        end
      end
      ST_RTS: begin
        if (clk_fall) begin
          edge_cnt_d = 4'd1;
          cnt_d      = '0;
          dat_oe_d   = ~data_q[0];
          state_d    = ST_SHIFT;
        end else if (cnt_q == CW'(START_CYC - 1)) begin
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          err_code_d = PS2_ERR_START;
          state_d    = ST_ERR;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CW'(FRAME_CYC - 1)) begin
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          err_code_d = PS2_ERR_FRAME;
          state_d    = ST_ERR;
        end else if (clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          case (edge_cnt_q)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
              dat_oe_d = ~data_q[edge_cnt_q[2:0]];
            4'd8:    dat_oe_d = ~par_q;
            4'd9:    dat_oe_d = 1'b0;
            4'd10: begin
              if (dat_level) begin
                clk_oe_d   = 1'b0;
                dat_oe_d   = 1'b0;
                err_code_d = PS2_ERR_NACK;
                state_d    = ST_ERR;
              end else begin
                state_d = ST_WAIT_IDLE;
              end
            end
            default: dat_oe_d = 1'b0;
          endcase
        end
      end
      ST_WAIT_IDLE: begin
        if (cnt_q == CW'(FRAME_CYC - 1)) begin
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          err_code_d = PS2_ERR_FRAME;
          state_d    = ST_ERR;
        end else if (clk_level && dat_level) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      err_code_q <= PS2_ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      err_code_q <= err_code_d;
    end
  end

  assign tx_if.tx_ready = (state_q == ST_IDLE);
  assign tx_if.busy     = (state_q != ST_IDLE);
  assign tx_if.done     = (state_q == ST_DONE);
  assign tx_if.err      = (state_q == ST_ERR);
  assign tx_if.err_code = err_code_q;
  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_dat_oe     = dat_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the counterpart of the existing PS/2 keyboard receiver. It sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It drives the shared ps2_clk/ps2_din lines through open-drain enables and runs the inhibit/request-to-send/ACK sequence. While a frame is in flight it asserts busy, which the receiver uses to ignore line activity.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
INHIBIT_US, 100, duration the clock line is held low before request-to-send
START_TIMEOUT_US, 15000, maximum wait from clock release to the first device falling edge
FRAME_TIMEOUT_US, 2000, maximum time from the first falling edge to ACK complete

Ports:
clk25  input  1  system clock, the only clock
rst  input  1  synchronous reset, active-high
tx_valid  input  1  byte request
tx_data  input  8  byte to send
tx_ready  output  1  high only in IDLE; a transfer is accepted on tx_valid & tx_ready
ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous)
ps2_dat_in  input  1  raw PS/2 data pin level (asynchronous)
ps2_clk_oe  output  1  1 = pull clock line low
ps2_dat_oe  output  1  1 = pull data line low
busy  output  1  high from accept until the DONE/ERR pulse
done  output  1  one-cycle pulse: byte ACKed by device
err  output  1  one-cycle pulse: transfer failed
err_code  output  2  valid with err: 01 start timeout, 10 NACK, 11 frame timeout

Behaviour:
- Reset values: tx_ready=1 (in IDLE), all other outputs 0; both lines released.
- Pin inputs pass through a 2-flop synchroniser. Falling edge detection is on the synchronised clock (prev=1, cur=0).
- Cycle constants: INHIBIT_CYC = CLK_HZ/1e6*INHIBIT_US (2500). START_CYC = 375000. FRAME_CYC = 50000. Counter width $clog2(START_CYC+1).
- Odd parity bit = ~^tx_data, computed at accept.
- States:
  - IDLE: on accept, latch data and parity; clk_oe=1 next cycle; go to INHIBIT.
  - INHIBIT: hold clk_oe=1 for INHIBIT_CYC cycles. On the last cycle set dat_oe=1 (start bit 0).
  - RTS: clk_oe=0, dat_oe=1. Wait for a falling edge, max START_CYC cycles, else ERR code 01.
  - SHIFT: falling-edge count n=1..11, frame timer armed at edge 1.
    - Edges 1..8: dat_oe = ~bit[n-1].
    - Edge 9: dat_oe = ~parity.
    - Edge 10: dat_oe=0 (stop bit).
    - Edge 11: sample data; 0 goes to WAIT_IDLE, 1 goes to ERR code 10.
  - WAIT_IDLE: wait until both synchronised lines are high; then DONE.
  - DONE: 1-cycle done pulse, then IDLE. ERR: 1-cycle err pulse, outputs released, then IDLE.
- Frame timer expiry in SHIFT/WAIT_IDLE goes to ERR code 11.
- Outputs are registered; a line change lands 1 cycle after the triggering edge detect, i.e. 3 cycles after the pin edge.
- tx_valid while busy is ignored; no queuing.
- rst asserted mid-frame: next cycle both oe=0, state IDLE, no done/err pulse.
- busy = (state != IDLE). busy deasserts in the same cycle tx_ready reasserts.

Optional Feature:
PS2_HOST_TX_GLITCH_FILTER_EN:
- Defined: the synchronised clock passes through a 4-cycle stability filter; a level change is accepted only after 4 equal consecutive samples. This adds 4 cycles of edge latency, and pulses under 4 cycles are ignored.
- Undefined: the raw synchroniser output is used directly.

Decomposition:
- Package ps2_pkg: state enum, err_code constants (PS2_ERR_START=2'b01, PS2_ERR_NACK=2'b10, PS2_ERR_FRAME=2'b11), and a parity helper function.
- Sub-module ps2_line_sync: 2-flop synchroniser, optional filter, falling-edge pulse. It is instantiated once for the clock and once for the data line (edge output unused there), and is reusable by the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and giving ACK -> data bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1; done pulse; err 0.
- Send 0x07 -> parity bit 0. Measure clk_oe low from accept to release = 2500 cycles ±1.
- Device never clocks -> err pulse with err_code 01 exactly 375000 cycles after RTS entry; lines released; tx_ready=1.
- Device leaves data high at edge 11 -> err with err_code 10. Device stops clocking after edge 5 -> err code 11 at 50000 cycles after edge 1.
- Assert rst for 1 cycle after edge 4 -> both oe=0 next cycle, no done/err. A new tx_valid then completes normally.
- With the filter macro defined, a 3-cycle low glitch on the clock in RTS -> ignored. A 4-cycle low pulse -> counted as edge 1.
